// File: rtl/timer_apb_seq.sv
// Autonomous APB master that programs the 8-bit timer, polls TSR for the end-of-count flag,
// then clears it. Optional repeat mode under `TIMER_APB_SEQ_AUTO_RELOAD_EN` adds evt_cnt.
module timer_apb_seq #(
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned POLL_MAX = 1024,
  parameter int unsigned PADDR_W  = 12
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         cfg_tdr,
  input  logic               cfg_dw,
  input  logic [1:0]         cfg_clk_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               irq,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [PADDR_W-1:0] paddr,
  output logic [7:0]         pwdata,
  input  logic [7:0]         prdata,
  input  logic               pready,
  input  logic               pslverr
`ifdef TIMER_APB_SEQ_AUTO_RELOAD_EN
  ,
  output logic [7:0]         evt_cnt
`endif
);

  localparam int unsigned PCW = $clog2(POLL_MAX) + 1;
  localparam int unsigned GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_TDR,
    S_WR_LOAD,
    S_WR_START,
    S_WAIT,
    S_RD_TSR,
    S_WR_CLR,
    S_WR_STOP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_ACCESS,
    PH_GAP
  } phase_t;

  state_t         r_state;
  state_t         w_state_nx;
  phase_t         r_ph;
  phase_t         w_ph_nx;
  logic [PCW-1:0] r_poll;
  logic [GCW-1:0] r_gap;
  logic [7:0]     r_tdr;
  logic           r_dw;
  logic [1:0]     r_clk_sel;
  logic           r_err;
  logic           r_flag;
  logic           r_slverr;

  logic           w_start_ok;
  logic           w_err_set;
  logic           w_poll_inc;
  logic           w_poll_clr;
  logic           w_poll_last;
  logic           w_gap_last;
  logic           w_xfer_done;
  logic [7:0]     w_flag_mask;

  assign w_poll_last = (r_poll >= PCW'(POLL_MAX - 1));
  assign w_gap_last  = (r_gap == GCW'(POLL_GAP - 1));
  assign w_xfer_done = psel & penable & pready;
  assign w_flag_mask = r_dw ? 8'h02 : 8'h01;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign irq  = (r_state == S_DONE);
  assign err  = r_err;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state <= S_IDLE;
      r_ph    <= PH_SETUP;
    end else begin
      r_state <= w_state_nx;
      r_ph    <= w_ph_nx;
    end
  end

  // Every transfer state runs SETUP, ACCESS (until pready), then one psel=0 cycle
  // in which the captured response, abort and the next state are resolved.
  always_comb begin
    w_state_nx = r_state;
    w_ph_nx    = r_ph;
    w_start_ok = 1'b0;
    w_err_set  = 1'b0;
    w_poll_inc = 1'b0;
    w_poll_clr = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ph_nx = PH_SETUP;
        if (start) begin
          w_start_ok = 1'b1;
          w_poll_clr = 1'b1;
          w_state_nx = S_WR_TDR;
        end
      end
      S_WAIT: begin
        w_ph_nx = PH_SETUP;
        if (abort) begin
          w_state_nx = S_WR_STOP;
        end else if (w_gap_last) begin
          w_state_nx = S_RD_TSR;
        end
      end
      S_DONE: begin
        w_ph_nx = PH_SETUP;
`ifdef TIMER_APB_SEQ_AUTO_RELOAD_EN
        w_poll_clr = 1'b1;
        w_state_nx = abort ? S_WR_STOP : S_WR_LOAD;
`else
        w_state_nx = S_IDLE;
`endif
      end
      default: begin
        psel    = (r_ph != PH_GAP);
        penable = (r_ph == PH_ACCESS);
        case (r_ph)
          PH_SETUP:  w_ph_nx = PH_ACCESS;
          PH_ACCESS: if (pready) w_ph_nx = PH_GAP;
          default: begin
            w_ph_nx = PH_SETUP;
            if (r_slverr) begin
              w_err_set  = 1'b1;
              w_state_nx = (r_state == S_WR_STOP) ? S_IDLE : S_WR_STOP;
            end else if (r_state == S_WR_STOP) begin
              w_state_nx = S_IDLE;
            end else if (abort) begin
              w_state_nx = S_WR_STOP;
            end else begin
              case (r_state)
                S_WR_TDR:   w_state_nx = S_WR_LOAD;
                S_WR_LOAD:  w_state_nx = S_WR_START;
                S_WR_START: w_state_nx = S_WAIT;
                S_RD_TSR: begin
                  if (r_flag) begin
                    w_state_nx = S_WR_CLR;
                  end else begin
                    w_poll_inc = 1'b1;
                    if (w_poll_last) begin
                      w_err_set  = 1'b1;
                      w_state_nx = S_WR_STOP;
                    end else begin
                      w_state_nx = S_WAIT;
                    end
                  end
                end
                S_WR_CLR:   w_state_nx = S_DONE;
                default:    w_state_nx = S_IDLE;
              endcase
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    pwrite = 1'b0;
    paddr  = '0;
    pwdata = '0;
    case (r_state)
      S_WR_TDR: begin
        pwrite = 1'b1;
        paddr  = PADDR_W'(12'h000);
        pwdata = r_tdr;
      end
      S_WR_LOAD: begin
        pwrite = 1'b1;
        paddr  = PADDR_W'(12'h001);
        pwdata = 8'h80;
      end
      S_WR_START: begin
        pwrite = 1'b1;
        paddr  = PADDR_W'(12'h001);
        pwdata = {2'b00, r_dw, 1'b1, 2'b00, r_clk_sel};
      end
      S_RD_TSR: begin
        paddr  = PADDR_W'(12'h002);
      end
      S_WR_CLR: begin
        pwrite = 1'b1;
        paddr  = PADDR_W'(12'h002);
      end
      S_WR_STOP: begin
        pwrite = 1'b1;
        paddr  = PADDR_W'(12'h001);
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_tdr     <= '0;
      r_dw      <= 1'b0;
      r_clk_sel <= '0;
      r_err     <= 1'b0;
      r_poll    <= '0;
      r_gap     <= '0;
      r_flag    <= 1'b0;
      r_slverr  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_tdr     <= cfg_tdr;
        r_dw      <= cfg_dw;
        r_clk_sel <= cfg_clk_sel;
      end
      if (w_start_ok) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_poll_clr) begin
        r_poll <= '0;
      end else if (w_poll_inc && (r_poll != PCW'(POLL_MAX))) begin
        r_poll <= r_poll + 1'b1;
      end
      if ((r_state == S_WAIT) && (w_state_nx == S_WAIT)) begin
        r_gap <= r_gap + 1'b1;
      end else begin
        r_gap <= '0;
      end
      if (w_xfer_done) begin
        r_slverr <= pslverr;
        r_flag   <= |(prdata & w_flag_mask);
      end
    end
  end

`ifdef TIMER_APB_SEQ_AUTO_RELOAD_EN
  logic [7:0] r_evt;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_evt <= '0;
    end else if (w_start_ok) begin
      r_evt <= '0;
    end else if (r_state == S_DONE) begin
      r_evt <= r_evt + 1'b1;
    end
  end

  assign evt_cnt = r_evt;
`endif

endmodule

// File: tb/tb_timer_apb_seq.sv
// Directed bench for timer_apb_seq: a scripted APB slave logs every completed transfer,
// and each scenario compares the log and status outputs with hand-computed values.
module tb_timer_apb_seq;

  logic        pclk;
  logic        preset;
  logic        start;
  logic        abort;
  logic [7:0]  cfg_tdr;
  logic        cfg_dw;
  logic [1:0]  cfg_clk_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic        irq;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pready;
  logic        pslverr;
`ifdef TIMER_APB_SEQ_AUTO_RELOAD_EN
  logic [7:0]  evt_cnt;
`endif

  timer_apb_seq #(
    .POLL_GAP(3),
    .POLL_MAX(4),
    .PADDR_W (12)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .start      (start),
    .abort      (abort),
    .cfg_tdr    (cfg_tdr),
    .cfg_dw     (cfg_dw),
    .cfg_clk_sel(cfg_clk_sel),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .irq        (irq),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
`ifdef TIMER_APB_SEQ_AUTO_RELOAD_EN
    ,
    .evt_cnt    (evt_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Slave script and transfer log.
  logic [7:0]  rsp [8];
  int          s_delay   = 0;
  int          s_err_idx = -1;
  int          s_wait    = 0;
  int          s_rd      = 0;
  int          n_log     = 0;
  logic        log_wr   [32];
  logic [11:0] log_addr [32];
  logic [7:0]  log_data [32];
  int          log_acc  [32];
  int          log_cyc  [32];
  int          n_done   = 0;
  int          n_irq    = 0;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  initial forever begin
    @(negedge pclk);
    if (done) n_done++;
    if (irq)  n_irq++;
  end

  initial begin
    pready  = 1'b0;
    prdata  = 8'h00;
    pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        if (s_wait < s_delay) begin
          pready = 1'b0;
          s_wait++;
        end else begin
          pready  = 1'b1;
          pslverr = (n_log == s_err_idx);
          if (!pwrite) begin
            prdata = rsp[(s_rd < 7) ? s_rd : 7];
            s_rd++;
          end
          if (n_log < 32) begin
            log_wr[n_log]   = pwrite;
            log_addr[n_log] = paddr;
            log_data[n_log] = pwrite ? pwdata : 8'h00;
            log_acc[n_log]  = s_wait + 1;
            log_cyc[n_log]  = cyc;
          end
          n_log++;
        end
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        s_wait  = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int i, input logic wr,
                         input logic [11:0] addr, input logic [7:0] data);
    check(tag, {11'd0, log_wr[i], log_addr[i], log_data[i]}, {11'd0, wr, addr, data});
  endtask

  task automatic clr_slave(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] rn);
    rsp[0] = r0;
    rsp[1] = r1;
    for (int i = 2; i < 8; i++) rsp[i] = rn;
    s_delay   = 0;
    s_err_idx = -1;
    s_rd      = 0;
    n_log     = 0;
    n_done    = 0;
    n_irq     = 0;
  endtask

  task automatic do_start(input logic [7:0] tdr, input logic dw, input logic [1:0] cs);
    @(negedge pclk);
    cfg_tdr     = tdr;
    cfg_dw      = dw;
    cfg_clk_sel = cs;
    start       = 1'b1;
    @(negedge pclk);
    start       = 1'b0;
    cfg_tdr     = ~tdr;
    cfg_dw      = ~dw;
    cfg_clk_sel = ~cs;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge pclk);
      #1;
      k++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge pclk);
      #1;
      k++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int k = 0;
    while (n_log < n && k < budget) begin
      @(negedge pclk);
      #1;
      k++;
    end
    check(tag, n_log, n);
  endtask

  initial begin
    preset      = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    cfg_tdr     = 8'h00;
    cfg_dw      = 1'b0;
    cfg_clk_sel = 2'b00;
    clr_slave(8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    check("rst_outputs", {busy, done, irq, err, psel, penable, pwrite}, 32'd0);
    check("rst_bus", {paddr, pwdata}, 32'd0);

    // Count-down single shot, flag on third read; a stray start mid-run is ignored.
    clr_slave(8'h00, 8'h00, 8'h02);
    do_start(8'hFF, 1'b1, 2'd0);
    check("cd_latency", {31'd0, psel}, 32'd1);
    repeat (3) @(negedge pclk);
    cfg_tdr = 8'h11;
    cfg_dw  = 1'b0;
    start   = 1'b1;
    @(negedge pclk);
    start   = 1'b0;
    wait_done("cd_done", 200);
    check("cd_irq", {31'd0, irq}, 32'd1);
    @(negedge pclk);
    check("cd_busy_after", {30'd0, busy, done}, 32'd0);
    check("cd_nlog", n_log, 7);
    chk_log("cd_tdr",   0, 1'b1, 12'h000, 8'hFF);
    chk_log("cd_load",  1, 1'b1, 12'h001, 8'h80);
    chk_log("cd_start", 2, 1'b1, 12'h001, 8'h30);
    chk_log("cd_rd0",   3, 1'b0, 12'h002, 8'h00);
    chk_log("cd_rd2",   5, 1'b0, 12'h002, 8'h00);
    chk_log("cd_clr",   6, 1'b1, 12'h002, 8'h00);
    check("cd_wr_spacing", log_cyc[1] - log_cyc[0], 3);
    check("cd_wr_spacing2", log_cyc[2] - log_cyc[1], 3);
    check("cd_poll_gap", log_cyc[4] - log_cyc[3], 6);
    check("cd_ndone", n_done, 1);
    check("cd_nirq", n_irq, 1);
    check("cd_err", {31'd0, err}, 32'd0);

    // pslverr on the TCR load write.
    clr_slave(8'h02, 8'h02, 8'h02);
    s_err_idx = 1;
    do_start(8'h3C, 1'b1, 2'd1);
    wait_idle("se_idle", 100);
    check("se_nlog", n_log, 3);
    chk_log("se_tdr",  0, 1'b1, 12'h000, 8'h3C);
    chk_log("se_load", 1, 1'b1, 12'h001, 8'h80);
    chk_log("se_stop", 2, 1'b1, 12'h001, 8'h00);
    check("se_err", {31'd0, err}, 32'd1);
    check("se_ndone", n_done, 0);

    // Count-up: a wrong-direction flag (TSR[1]) must not end the poll.
    clr_slave(8'h02, 8'h02, 8'h01);
    do_start(8'hF0, 1'b0, 2'd0);
    check("cu_err_cleared", {31'd0, err}, 32'd0);
    wait_done("cu_done", 200);
    @(negedge pclk);
    check("cu_busy_after", {31'd0, busy}, 32'd0);
    check("cu_nlog", n_log, 7);
    chk_log("cu_tdr",   0, 1'b1, 12'h000, 8'hF0);
    chk_log("cu_start", 2, 1'b1, 12'h001, 8'h10);
    chk_log("cu_clr",   6, 1'b1, 12'h002, 8'h00);
    check("cu_ndone", n_done, 1);

    // Timeout after POLL_MAX reads with no flag.
    clr_slave(8'h00, 8'h00, 8'h00);
    do_start(8'h5A, 1'b1, 2'd3);
    wait_idle("to_idle", 300);
    check("to_nlog", n_log, 8);
    chk_log("to_start", 2, 1'b1, 12'h001, 8'h33);
    chk_log("to_rd3",   6, 1'b0, 12'h002, 8'h00);
    chk_log("to_stop",  7, 1'b1, 12'h001, 8'h00);
    check("to_nreads", s_rd, 4);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_ndone", n_done + n_irq, 0);

    // Abort during WAIT; the stop write sees a 3-cycle pready delay.
    clr_slave(8'h00, 8'h00, 8'h00);
    do_start(8'hFF, 1'b1, 2'd0);
    wait_log("ab_started", 3, 100);
    repeat (2) @(negedge pclk);
    abort   = 1'b1;
    s_delay = 3;
    wait_idle("ab_idle", 100);
    repeat (3) @(negedge pclk);
    check("ab_idle_hold", {31'd0, busy}, 32'd0);
    abort = 1'b0;
    check("ab_nlog", n_log, 4);
    chk_log("ab_stop", 3, 1'b1, 12'h001, 8'h00);
    check("ab_stop_acc", log_acc[3], 4);
    check("ab_ndone", n_done, 0);
    check("ab_err", {31'd0, err}, 32'd0);

    // Asynchronous reset in the middle of an ACCESS phase.
    clr_slave(8'h00, 8'h00, 8'h00);
    s_delay = 6;
    do_start(8'hFF, 1'b1, 2'd0);
    @(negedge pclk);
    #1;
    check("rs_in_access", {30'd0, psel, penable}, 32'd3);
    preset = 1'b1;
    #1;
    check("rs_async", {29'd0, psel, penable, busy}, 32'd0);
    #1;
    preset = 1'b0;
    @(negedge pclk);
    check("rs_after", {30'd0, busy, psel}, 32'd0);

`ifdef TIMER_APB_SEQ_AUTO_RELOAD_EN
    // Repeat mode: three underflow events, then abort.
    clr_slave(8'h02, 8'h02, 8'h02);
    do_start(8'h10, 1'b1, 2'd0);
    begin
      int k = 0;
      while (n_done < 3 && k < 400) begin
        @(negedge pclk);
        #1;
        k++;
      end
    end
    abort = 1'b1;
    wait_idle("ar_idle", 100);
    abort = 1'b0;
    check("ar_evt_cnt", {24'd0, evt_cnt}, 32'd3);
    check("ar_ndone", n_done, 3);
    check("ar_nirq", n_irq, 3);
    chk_log("ar_reload", 5, 1'b1, 12'h001, 8'h80);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_apb_seq.md
Name: timer_apb_seq

Overview:
- Autonomous APB master that sequences the 8-bit timer peripheral (TDR @0x000, TCR @0x001, TSR @0x002) without CPU involvement.
- On a start pulse it programs the reload value, loads the counter, starts counting, then polls TSR until overflow/underflow.
- It then clears TSR and signals done/irq.
- Sits on the APB side next to the AHB-to-APB bridge, driving the timer's PSEL slot through the APB mux.

Parameters:
- POLL_GAP, 16, idle pclk cycles between successive TSR reads while waiting.
- POLL_MAX, 1024, maximum TSR reads before timeout error.
- PADDR_W, 12, APB address width.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  level; stop timer and return to IDLE.
- cfg_tdr  in  8  reload value written to TDR.
- cfg_dw  in  1  1 = count down (wait underflow TSR[1]); 0 = count up (wait overflow TSR[0]).
- cfg_clk_sel  in  2  TCR[1:0] clock divider select.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a sequence completes (flag seen and cleared).
- err  out  1  sticky; set on pslverr or timeout; cleared by the next accepted start.
- irq  out  1  one-cycle pulse coincident with done.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  PADDR_W  APB address.
- pwdata  out  8  APB write data.
- prdata  in  8  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Reset: async on preset=1. All outputs 0, state IDLE, poll and gap counters 0, latched cfg 0.
- start accepted in IDLE: latch cfg_tdr, cfg_dw and cfg_clk_sel; clear err. start in any other state is ignored.
- APB transfer rules:
  - SETUP: one cycle, psel=1, penable=0, paddr/pwrite/pwdata valid.
  - ACCESS: psel=1, penable=1, held until pready=1.
  - Outputs stable across SETUP and ACCESS.
  - After completion psel=0 for at least one cycle; no back-to-back transfers.
  - prdata is captured on the cycle where penable and pready are both 1.
- States and transactions:
  - IDLE.
  - WR_TDR: write 0x000 <= cfg_tdr.
  - WR_LOAD: write 0x001 <= 0x80.
  - WR_START: write 0x001 <= {2'b00, cfg_dw, 1'b1, 2'b00, cfg_clk_sel}.
  - WAIT: count POLL_GAP cycles.
  - RD_TSR: read 0x002.
  - WR_CLR: write 0x002 <= 0x00.
  - WR_STOP: write 0x001 <= 0x00.
  - DONE.
- Transitions:
  - IDLE -start-> WR_TDR -> WR_LOAD -> WR_START -> WAIT -> RD_TSR.
  - RD_TSR: flag bit set (TSR[1] if cfg_dw, else TSR[0]) -> WR_CLR -> DONE -> IDLE. Otherwise increment poll count and return to WAIT.
  - Timeout: poll count reaching POLL_MAX with no flag -> set err -> WR_STOP -> IDLE. done is not pulsed.
- Error: pslverr=1 at completion of any transfer sets err.
  - From WR_STOP itself: go to IDLE.
  - From any other state: go to WR_STOP.
- Abort:
  - Sampled only between transfers (psel=0). An in-flight APB transfer always completes first.
  - Then go to WR_STOP -> IDLE; no done/irq.
  - abort in IDLE has no effect.
- Timing:
  - done/irq assert for exactly one cycle, in the DONE state; busy=0 the cycle after.
  - Minimum latency start -> first psel: 1 cycle.
  - With zero-wait slave: 3 writes at 2 cycles each plus 1 idle cycle each.
- Counters: poll count is log2(POLL_MAX)+1 bits and saturates; gap count wraps to 0 on leaving WAIT.
- Reset mid-transfer: psel/penable drop immediately. The timer is not stopped by this block; the system reset covers it.

Optional Feature:
- Macro TIMER_APB_SEQ_AUTO_RELOAD_EN.
- Defined:
  - DONE transitions to WR_LOAD instead of IDLE, so the sequence repeats until abort.
  - done/irq pulse once per event.
  - Adds output evt_cnt [7:0]: increments on each done, wraps 0xFF->0x00, cleared by accepted start.
- Undefined: single-shot sequence as above; evt_cnt port absent.

Test Plan:
- Count-down single shot: cfg_tdr=0xFF, cfg_dw=1, cfg_clk_sel=0, start.
  - APB writes appear in order: 0x000<=0xFF, 0x001<=0x80, 0x001<=0x30.
  - TSR polled until 0x02, then 0x002<=0x00 written.
  - done/irq pulse once; err=0.
- Count-up: cfg_tdr=0xF0, cfg_dw=0 -> 0x001<=0x10 written; completes when TSR[0]=1; done pulse.
- Timeout: POLL_MAX=4, slave returns TSR=0x00 -> exactly 4 reads, then 0x001<=0x00, err=1, no done.
- pslverr on the WR_LOAD transfer -> err=1; next transfer is 0x001<=0x00; IDLE after; a new start clears err.
- Abort in WAIT with pready delayed 3 cycles on the stop write -> stop write held until pready; busy=0 afterwards.
  - preset pulse mid-ACCESS -> psel, penable, busy all 0 asynchronously.
- With TIMER_APB_SEQ_AUTO_RELOAD_EN: 3 underflows -> evt_cnt=3, three done pulses; abort -> IDLE.
